spike_current_accumulator: RTL and testbench

Parametrised successor to the single-cycle input-current stage of the SNN neuron datapath. Sums the weights of all active input spikes over ceil-free multi-cycle passes, processing LANES synapses per clock, with a correct wide accumulator and saturation to the output width. Uses a start/busy/done handshake, so the neuron controller can trigger one current evaluation per timestep and consume the result when done pulses. Supports signed or unsigned weight interpretation.

---
 rtl/spike_current_accumulator.sv | 105 ++++++++++
 tb/tb_spike_current_accumulator.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/spike_current_accumulator.sv
// spike_current_accumulator: multi-cycle weighted spike sum with saturation and start/busy/done handshake
module spike_current_accumulator #(
  parameter int M        = 24,
  parameter int W_BITS   = 8,
  parameter int OUT_BITS = 8,
  parameter int LANES    = 4,
  parameter int SIGNED_W = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [M-1:0]          input_spikes,
  input  logic [M*W_BITS-1:0]   weights,
  output logic                  busy,
  output logic                  done,
  output logic [OUT_BITS-1:0]   input_current,
  output logic                  saturated
);
  localparam int G        = M / LANES;
  localparam int ACC_BITS = W_BITS + $clog2(M) + 1;
  localparam int GW       = G > 1 ? $clog2(G) : 1;
  localparam longint HI   = SIGNED_W != 0 ? (64'sd1 <<< (OUT_BITS - 1)) - 64'sd1 : (64'sd1 <<< OUT_BITS) - 64'sd1;
  localparam longint LO   = SIGNED_W != 0 ? -(64'sd1 <<< (OUT_BITS - 1)) : 64'sd0;

  if (M % LANES != 0) begin : g_lanes_check
    $error("M must be an integer multiple of LANES");
  end

  typedef enum logic [1:0] {IDLE, ACCUM, FINISH} state_t;

  state_t                state_q, state_d;
  logic [M-1:0]          spk_q;
  logic [ACC_BITS-1:0]   acc_q, lane_sum;
  logic [GW-1:0]         g_q;
  logic                  g_last;
  logic [W_BITS-1:0]     w;
  logic signed [ACC_BITS:0] acc_x;
  logic                  busy_q, done_q, sat_q, busy_d, done_d, sat_d, over, under;
  logic [OUT_BITS-1:0]   cur_q, cur_d;

  assign g_last        = g_q == GW'(G - 1);
  assign busy          = busy_q;
  assign done          = done_q;
  assign input_current = cur_q;
  assign saturated     = sat_q;

  // state register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;

  // next-state: one ACCUM cycle per lane group, then a single FINISH cycle
  always_comb
    state_d = state_q == IDLE  ? (start ? ACCUM : IDLE) :
              state_q == ACCUM ? (g_last ? FINISH : ACCUM) : IDLE;

  // sum of the current group's gated weights, extended to the accumulator width
  always_comb begin
    lane_sum = '0;
    w = '0;
    for (int k = 0; k < LANES; k++) begin
      w = weights[(int'(g_q) * LANES + k) * W_BITS +: W_BITS];
      lane_sum = lane_sum + (spk_q[int'(g_q) * LANES + k] ?
                 {{(ACC_BITS - W_BITS){SIGNED_W != 0 && w[W_BITS-1]}}, w} : '0);
    end
  end

  // outputs: busy spans through the done cycle; clamp the sum to the output range
  always_comb begin
    done_d = state_q == FINISH;
    busy_d = state_d != IDLE || done_d;
    acc_x  = {SIGNED_W != 0 && acc_q[ACC_BITS-1], acc_q};
    over   = longint'(acc_x) > HI;
    under  = longint'(acc_x) < LO;
    cur_d  = over ? OUT_BITS'(HI) : under ? OUT_BITS'(LO) : OUT_BITS'(acc_x);
    sat_d  = over || under;
  end

  // datapath: latch spikes on accept, accumulate per group, publish result in FINISH
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      spk_q  <= '0;
      acc_q  <= '0;
      g_q    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cur_q  <= '0;
      sat_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      if (state_q == IDLE && start) begin
        spk_q <= input_spikes;
        acc_q <= '0;
        g_q   <= '0;
      end else if (state_q == ACCUM) begin
        acc_q <= acc_q + lane_sum;
        g_q   <= g_last ? '0 : g_q + 1'b1;
      end
      if (state_q == FINISH) begin
        cur_q <= cur_d;
        sat_q <= sat_d;
      end
    end
endmodule

// File: tb/tb_spike_current_accumulator.sv
// tb_spike_current_accumulator: directed vectors on a signed 8-bit and an unsigned 10-bit instance
module tb_spike_current_accumulator;
  logic         clk = 1'b0, reset_n = 1'b0, start = 1'b0;
  logic [23:0]  spk = '0;
  logic [191:0] wts = '0;
  logic         busy_s, done_s, sat_s, busy_u, done_u, sat_u;
  logic [7:0]   cur_s;
  logic [9:0]   cur_u;
  int           checks = 0, errors = 0;

  typedef struct {
    logic [23:0]  spk;
    logic [191:0] wts;
    logic [7:0]   cur_s;
    logic         sat_s;
    logic [9:0]   cur_u;
    logic         sat_u;
  } vec_t;

  spike_current_accumulator #(.M(24), .W_BITS(8), .OUT_BITS(8), .LANES(4), .SIGNED_W(1)) u_s (
    .clk(clk), .reset_n(reset_n), .start(start), .input_spikes(spk), .weights(wts),
    .busy(busy_s), .done(done_s), .input_current(cur_s), .saturated(sat_s));

  spike_current_accumulator #(.M(24), .W_BITS(8), .OUT_BITS(10), .LANES(4), .SIGNED_W(0)) u_u (
    .clk(clk), .reset_n(reset_n), .start(start), .input_spikes(spk), .weights(wts),
    .busy(busy_u), .done(done_u), .input_current(cur_u), .saturated(sat_u));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic start_run(input logic [23:0] s, input logic [191:0] w);
    spk = s;
    wts = w;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    int bad = 0;
    n = 0;
    do begin
      @(posedge clk);
      #1 n++;
      if (!busy_s || !busy_u) bad++;
    end while (!done_s && n < 20);
    chk("busy_during_run", bad, 0);
  endtask

  task automatic check_result(input string tag, input vec_t v);
    chk({tag, "_cur_s"}, cur_s, v.cur_s);
    chk({tag, "_sat_s"}, sat_s, v.sat_s);
    chk({tag, "_cur_u"}, cur_u, v.cur_u);
    chk({tag, "_sat_u"}, sat_u, v.sat_u);
  endtask

  initial begin
    vec_t vecs[9];
    logic [191:0] w;
    int n;
    w = '0;
    w[0*8 +: 8] = 8'd10;
    w[5*8 +: 8] = 8'd20;
    w[23*8 +: 8] = 8'hFB;
    vecs[0] = '{24'h000000, {24{8'h7F}}, 8'h00, 1'b0, 10'd0,    1'b0};
    vecs[1] = '{24'h800021, w,           8'h19, 1'b0, 10'd281,  1'b0};
    vecs[2] = '{24'hFFFFFF, {24{8'h7F}}, 8'h7F, 1'b1, 10'd1023, 1'b1};
    vecs[3] = '{24'hFFFFFF, {24{8'h80}}, 8'h80, 1'b1, 10'd1023, 1'b1};
    vecs[4] = '{24'h00000F, {24{8'hC8}}, 8'h80, 1'b1, 10'd800,  1'b0};
    vecs[5] = '{24'h0000FF, {24{8'hC8}}, 8'h80, 1'b1, 10'd1023, 1'b1};
    w = {24{8'h7F}};
    w[3*8 +: 8] = 8'h40;
    w[4*8 +: 8] = 8'h40;
    vecs[6] = '{24'h000018, w,           8'h7F, 1'b1, 10'd128,  1'b0};
    w = {24{8'h7F}};
    w[22*8 +: 8] = 8'h40;
    w[23*8 +: 8] = 8'h3F;
    vecs[7] = '{24'hC00000, w,           8'h7F, 1'b0, 10'd127,  1'b0};
    vecs[8] = '{24'hC00000, {24{8'hC0}}, 8'h80, 1'b0, 10'd384,  1'b0};

    #1;
    chk("reset_busy", {busy_s, busy_u}, 0);
    chk("reset_done", {done_s, done_u}, 0);
    chk("reset_cur", {cur_s, cur_u}, 0);
    chk("reset_sat", {sat_s, sat_u}, 0);
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) begin
      start_run(vecs[i].spk, vecs[i].wts);
      wait_done(n);
      chk($sformatf("v%0d_latency", i), n, 7);
      chk($sformatf("v%0d_done_u", i), done_u, 1);
      check_result($sformatf("v%0d", i), vecs[i]);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_idle_after", i), {busy_s, done_s, busy_u, done_u}, 0);
    end

    start_run(vecs[7].spk, vecs[7].wts);
    @(posedge clk);
    #1 start = 1'b1;
    spk = 24'hFFFFFF;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      #1 n++;
    end while (!done_s && n < 20);
    chk("ignored_start_latency", n, 5);
    check_result("ignored_start", vecs[7]);
    start_run(vecs[4].spk, vecs[4].wts);
    chk("b2b_busy_held", {busy_s, busy_u}, 2'b11);
    wait_done(n);
    chk("b2b_latency", n, 7);
    check_result("b2b", vecs[4]);

    @(posedge clk);
    #1;
    start_run(vecs[1].spk, vecs[1].wts);
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_busy", {busy_s, busy_u}, 0);
    chk("abort_done", {done_s, done_u}, 0);
    chk("abort_cur", {cur_s, cur_u}, 0);
    chk("abort_sat", {sat_s, sat_u}, 0);
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_no_done", {done_s, done_u, busy_s, busy_u}, 0);
    start_run(vecs[1].spk, vecs[1].wts);
    wait_done(n);
    chk("fresh_latency", n, 7);
    check_result("fresh", vecs[1]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
